// File: rtl/hl_clk_supervisor.sv
// Clock-source supervisor: measures candidate ADC clocks and picks a healthy one.
// Every source change goes through a gated select update while the core is held in reset.
module hl_clk_supervisor #(
  parameter int NCLK        = 2,
  parameter int SELW        = NCLK > 1 ? $clog2(NCLK) : 1,
  parameter int WINDOW      = 1024,
  parameter int MIN_EDGES   = 200,
  parameter int MAX_EDGES   = 300,
  parameter int HYST        = 3,
  parameter int GATE_CYCLES = 4,
  parameter int RST_HOLD    = 16,
  parameter int DEFAULT_SEL = 1
) (
  input  logic            clk,
  input  logic            extreset,
  input  logic [NCLK-1:0] mon,
  input  logic            force_en,
  input  logic [SELW-1:0] force_sel,
  output logic [SELW-1:0] clk_sel,
  output logic [NCLK-1:0] present,
  output logic            core_rst_n,
  output logic            switching,
  output logic            locked
);

  localparam int CW   = $clog2(MAX_EDGES + 2);
  localparam int WW   = WINDOW > 1 ? $clog2(WINDOW) : 1;
  localparam int HW   = $clog2(HYST + 1);
  localparam int TMAX = GATE_CYCLES > RST_HOLD ? GATE_CYCLES : RST_HOLD;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [CW-1:0]   E_SAT = CW'(MAX_EDGES + 1);
  localparam logic [CW-1:0]   E_MIN = CW'(MIN_EDGES);
  localparam logic [CW-1:0]   E_MAX = CW'(MAX_EDGES);
  localparam logic [HW-1:0]   H_SAT = HW'(HYST);
  localparam logic [HW-1:0]   H_PRE = HW'(HYST - 1);
  localparam logic [WW-1:0]   W_END = WW'(WINDOW - 1);
  localparam logic [TW-1:0]   T_GATE = TW'(GATE_CYCLES - 1);
  localparam logic [TW-1:0]   T_HOLD = TW'(RST_HOLD - 1);
  localparam logic [SELW-1:0] DEF   = SELW'(DEFAULT_SEL);

  typedef enum logic [1:0] {
    S_INIT,
    S_GATE,
    S_HOLD,
    S_RUN
  } state_t;

  logic [NCLK-1:0] s1, s2, s3, s4;
  logic [NCLK-1:0] rise;
  logic [WW-1:0]   win_cnt;
  logic            win_end;
  logic            eval;
  logic [CW-1:0]   ecnt     [NCLK];
  logic [CW-1:0]   ecnt_nxt [NCLK];
  logic [NCLK-1:0] good;
  logic [HW-1:0]   gcnt     [NCLK];
  logic [SELW-1:0] desired;
  logic [SELW-1:0] tgt;
  logic [TW-1:0]   tmr;
  state_t          state;

  // three sync flops, the fourth only remembers the previous level
  always_ff @(posedge clk or negedge extreset) begin
    if (!extreset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      s4 <= '0;
    end else begin
      s1 <= mon;
      s2 <= s1;
      s3 <= s2;
      s4 <= s3;
    end
  end

  assign rise    = s3 & ~s4;
  assign win_end = (win_cnt == W_END);

  always_ff @(posedge clk or negedge extreset) begin
    if (!extreset) begin
      win_cnt <= '0;
      eval    <= 1'b0;
    end else begin
      win_cnt <= win_end ? '0 : win_cnt + 1'b1;
      eval    <= win_end;
    end
  end

  always_comb begin
    good = '0;
    for (int i = 0; i < NCLK; i++) begin
      ecnt_nxt[i] = ecnt[i];
      if (rise[i] && ecnt[i] != E_SAT)
        ecnt_nxt[i] = ecnt[i] + 1'b1;
      good[i] = (ecnt_nxt[i] >= E_MIN) && (ecnt_nxt[i] <= E_MAX);
    end
  end

  // window judged on the count including an edge landing on win_end itself
  always_ff @(posedge clk or negedge extreset) begin
    if (!extreset) begin
      present <= '0;
      for (int i = 0; i < NCLK; i++) begin
        ecnt[i] <= '0;
        gcnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCLK; i++) begin
        if (win_end) begin
          ecnt[i] <= '0;
          if (good[i]) begin
            if (gcnt[i] != H_SAT)
              gcnt[i] <= gcnt[i] + 1'b1;
            if (gcnt[i] >= H_PRE)
              present[i] <= 1'b1;
          end else begin
            gcnt[i]    <= '0;
            present[i] <= 1'b0;
          end
        end else begin
          ecnt[i] <= ecnt_nxt[i];
        end
      end
    end
  end

  always_comb begin
    desired = DEF;
    for (int i = NCLK - 1; i >= 0; i--)
      if (present[i])
        desired = SELW'(i);
    if (force_en && (int'(force_sel) < NCLK))
      desired = force_sel;
  end

  always_ff @(posedge clk or negedge extreset) begin
    if (!extreset) begin
      state      <= S_INIT;
      tmr        <= '0;
      tgt        <= DEF;
      clk_sel    <= DEF;
      core_rst_n <= 1'b0;
      switching  <= 1'b0;
      locked     <= 1'b0;
    end else begin
      unique case (state)
        S_INIT: begin
          if (eval) begin
            tgt       <= desired;
            tmr       <= '0;
            switching <= 1'b1;
            state     <= S_GATE;
          end
        end
        S_GATE: begin
          if (tmr == T_GATE) begin
            clk_sel <= tgt;
            tmr     <= '0;
            state   <= S_HOLD;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        S_HOLD: begin
          if (tmr == T_HOLD) begin
            switching  <= 1'b0;
            locked     <= 1'b1;
            core_rst_n <= 1'b1;
            state      <= S_RUN;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        S_RUN: begin
          if (eval && desired != clk_sel) begin
            tgt        <= desired;
            tmr        <= '0;
            switching  <= 1'b1;
            locked     <= 1'b0;
            core_rst_n <= 1'b0;
            state      <= S_GATE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hl_clk_supervisor.sv
// Scoreboard bench for hl_clk_supervisor: window-level reference model,
// expectations queued at window start, popped by independent monitors.
module tb_hl_clk_supervisor;

  localparam int WIN  = 1024;
  localparam int NW   = 35;
  localparam int NSCR = 21;

  logic       clk = 1'b0;
  logic       extreset = 1'b0;
  logic [1:0] mon = '0;
  logic       force_en = 1'b0;
  logic [0:0] force_sel = '0;
  logic [0:0] clk_sel;
  logic [1:0] present;
  logic       core_rst_n;
  logic       switching;
  logic       locked;

  hl_clk_supervisor dut (
    .clk       (clk),
    .extreset  (extreset),
    .mon       (mon),
    .force_en  (force_en),
    .force_sel (force_sel),
    .clk_sel   (clk_sel),
    .present   (present),
    .core_rst_n(core_rst_n),
    .switching (switching),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;

  int h[2]  = '{0, 0};
  int hc[2] = '{0, 0};

  logic [1:0] pres_q[$];
  int         sw_q[$];

  int s_h0[NSCR] = '{0,0,0,2,2,2,2,0,0,1,1,1,2,2,2,2,2,2,2,2,2};
  int s_h1[NSCR] = '{2,2,2,2,2,2,2,2,2,2,2,2,2,2,2,2,2,2,2,2,3};
  int s_fe[NSCR] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,1,0,0,0};
  int s_fs[NSCR] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,1,0,0,0};
  int opts[6]    = '{0, 1, 2, 2, 2, 3};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // half-period h[i] in clk cycles; 0 means the source is idle
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (h[i] != 0) begin
        hc[i]++;
        if (hc[i] >= h[i]) begin
          hc[i]  = 0;
          mon[i] = ~mon[i];
        end
      end
    end
  end

  task automatic stim();
    int gc[2] = '{0, 0};
    int cur = 1;
    for (int k = 0; k < NW; k++) begin
      int fe;
      int fs;
      int des;
      logic [1:0] pres;
      if (k < NSCR) begin
        h[0] = s_h0[k];
        h[1] = s_h1[k];
        fe = s_fe[k];
        fs = s_fs[k];
      end else begin
        for (int i = 0; i < 2; i++)
          if ($urandom_range(0, 2) == 0)
            h[i] = opts[$urandom_range(0, 5)];
        fe = ($urandom_range(0, 3) == 0) ? 1 : 0;
        fs = $urandom_range(0, 1);
      end
      // only a 2-cycle half-period lands inside 200..300 edges per window
      for (int i = 0; i < 2; i++) begin
        if (h[i] == 2)
          gc[i] = (gc[i] < 3) ? gc[i] + 1 : 3;
        else
          gc[i] = 0;
        pres[i] = (gc[i] >= 3);
      end
      if (fe != 0 && fs < 2) des = fs;
      else if (pres[0]) des = 0;
      else if (pres[1]) des = 1;
      else des = 1;
      pres_q.push_back(pres);
      if (k == 0 || des != cur) begin
        sw_q.push_back(des);
        cur = des;
      end
      repeat (WIN / 2) @(posedge clk);
      @(negedge clk);
      force_en  = (fe != 0);
      force_sel = fs[0:0];
      repeat (WIN / 2) @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic pres_mon();
    for (int k = 0; k < NW; k++) begin
      repeat (WIN) @(posedge clk);
      @(negedge clk);
      if (pres_q.size() == 0)
        chk($sformatf("present_q_empty_w%0d", k), 1, 0);
      else
        chk($sformatf("present_w%0d", k), present, pres_q.pop_front());
    end
  endtask

  initial begin
    int   prev_sel = 1;
    logic prev_sw  = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_on && switching && !prev_sw) begin
        int tgt;
        int len;
        if (sw_q.size() == 0) begin
          chk("unexpected_switch", 1, 0);
          tgt = prev_sel;
        end else begin
          tgt = sw_q.pop_front();
        end
        chk("rst_low_at_gate", core_rst_n, 0);
        len = 0;
        while (switching && len < 100) begin
          if (len == 3) chk("sel_before_change", clk_sel, prev_sel);
          if (len == 4) chk("sel_after_change", clk_sel, tgt);
          len++;
          @(negedge clk);
        end
        chk("switch_len", len, 20);
        chk("locked_after", locked, 1);
        chk("rst_after", core_rst_n, 1);
        chk("sel_final", clk_sel, tgt);
        prev_sel = tgt;
      end
      prev_sw = switching;
    end
  end

  always @(negedge clk) begin
    if (mon_on && extreset) begin
      chk("sw_lock_excl", int'(switching && locked), 0);
      chk("lock_vs_rst", locked, core_rst_n);
    end
  end

  initial begin
    extreset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_clk_sel", clk_sel, 1);
    chk("rst_present", present, 0);
    chk("rst_core_rst_n", core_rst_n, 0);
    chk("rst_switching", switching, 0);
    chk("rst_locked", locked, 0);
    extreset = 1'b1;
    mon_on = 1'b1;
    fork
      stim();
      pres_mon();
    join
    repeat (50) @(negedge clk);
    chk("switch_q_drained", sw_q.size(), 0);
    chk("present_q_drained", pres_q.size(), 0);
    mon_on = 1'b0;

    // reset in the middle of the INIT switch, then a clean INIT pass
    extreset  = 1'b0;
    h[0]      = 0;
    h[1]      = 2;
    force_en  = 1'b0;
    force_sel = '0;
    repeat (2) @(negedge clk);
    extreset = 1'b1;
    repeat (WIN + 1) @(posedge clk);
    @(negedge clk);
    chk("gate_entered", switching, 1);
    #2;
    extreset = 1'b0;
    #1;
    chk("async_clk_sel", clk_sel, 1);
    chk("async_present", present, 0);
    chk("async_core_rst_n", core_rst_n, 0);
    chk("async_switching", switching, 0);
    chk("async_locked", locked, 0);
    @(negedge clk);
    extreset = 1'b1;
    repeat (WIN + 20) @(posedge clk);
    @(negedge clk);
    chk("init_rst_still_low", core_rst_n, 0);
    chk("init_switching", switching, 1);
    @(posedge clk);
    @(negedge clk);
    chk("init_rst_release", core_rst_n, 1);
    chk("init_locked", locked, 1);
    chk("init_switch_done", switching, 0);
    chk("init_clk_sel", clk_sel, 1);
    repeat (3 * WIN - (WIN + 21) - 1) @(posedge clk);
    @(negedge clk);
    chk("present_before_3rd", present, 0);
    @(posedge clk);
    @(negedge clk);
    chk("present_after_3rd", present, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
